// File: rtl/dvbc_pkg.sv
// dvbc_pkg: shared constants, word type and branch-geometry helpers for the
// DVB-C convolutional (Forney) interleaver/deinterleaver, I=12, M=17.
`default_nettype none

package dvbc_pkg;

  localparam int I         = 12;
  localparam int M         = 17;
  localparam int W         = 8;
  localparam logic [7:0] SYNC_BYTE = 8'h47;
  localparam int DEPTH     = M * I * (I - 1) / 2;
  localparam int FILL_LEN  = (I - 1) * M * I;
  localparam int AW        = $clog2(DEPTH);
  localparam int PW        = $clog2((I - 1) * M);
  localparam int BW        = $clog2(I);
  localparam int FW        = $clog2(FILL_LEN + 1);

  typedef struct packed {
    logic         sync;
    logic [W-1:0] data;
  } word_t;

  // Start address of branch j: M * sum_{k<j} (I-1-k), in closed form.
  function automatic int branch_base(input int j);
    return M * (j * (I - 1) - (j * (j - 1)) / 2);
  endfunction

  function automatic int branch_len(input int j);
    return (I - 1 - j) * M;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dvbc_spram.sv
// dvbc_spram: single-port synchronous RAM, read-first, registered read data.
// Contents are never reset.
`default_nettype none

module dvbc_spram #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 1122,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        mem[addr] <= wdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dvbc_deinterleaver.sv
// dvbc_deinterleaver: DVB-C Forney deinterleaver; branch j is delayed by
// (I-1-j)*M branch visits using circular regions of one shared RAM.
`default_nettype none

module dvbc_deinterleaver
  import dvbc_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  input  logic         sync_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         sync_o,
  output logic         locked_o,
  output logic         filled_o,
  output logic         resync_o
);

  logic [BW-1:0] branch_cnt;
  logic [BW-1:0] branch;
  logic [PW-1:0] ptr [I-1];
  logic [FW-1:0] fill_cnt;
  logic          locked;
  logic          out_valid;
  logic          out_ram;
  logic          resync;
  logic          accept;
  logic          realign;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  word_t         in_word;
  word_t         byp_word;
  word_t         ram_rdata;
  word_t         out_word;

  assign accept  = valid_i && (locked || sync_i);
  assign realign = accept && sync_i && locked && (branch_cnt != '0);
  assign branch  = sync_i ? '0 : branch_cnt;
  assign ram_en  = accept && (branch != BW'(I - 1));
  assign in_word = '{sync: sync_i, data: data_i};

  always_comb begin
    ram_addr = '0;
    for (int j = 0; j < I - 1; j++) begin
      if (branch == BW'(j)) begin
        ram_addr = AW'(branch_base(j)) + AW'(ptr[j]);
      end
    end
  end

  dvbc_spram #(
    .WIDTH ($bits(word_t)),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i (clk_i),
    .en    (ram_en),
    .we    (ram_en),
    .addr  (ram_addr),
    .wdata (in_word),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt <= '0;
      fill_cnt   <= '0;
      locked     <= 1'b0;
      out_valid  <= 1'b0;
      out_ram    <= 1'b0;
      resync     <= 1'b0;
      byp_word   <= '0;
      for (int j = 0; j < I - 1; j++) begin
        ptr[j] <= '0;
      end
    end else begin
      out_valid <= accept;
      resync    <= realign;
      if (accept) begin
        locked     <= 1'b1;
        out_ram    <= ram_en;
        branch_cnt <= (branch == BW'(I - 1)) ? '0 : branch + 1'b1;
        if (!ram_en) begin
          byp_word <= in_word;
        end
        for (int j = 0; j < I - 1; j++) begin
          if (branch == BW'(j)) begin
            ptr[j] <= (ptr[j] == PW'(branch_len(j) - 1)) ? '0 : ptr[j] + 1'b1;
          end
        end
        // The realigning sync byte is itself the first post-alignment byte.
        if (realign) begin
          fill_cnt <= FW'(1);
        end else if (fill_cnt != FW'(FILL_LEN)) begin
          fill_cnt <= fill_cnt + 1'b1;
        end
      end
    end
  end

  assign out_word = out_ram ? ram_rdata : byp_word;
  assign data_o   = out_valid ? out_word.data : '0;
  assign sync_o   = out_valid & out_word.sync;
  assign valid_o  = out_valid;
  assign locked_o = locked;
  assign filled_o = (fill_cnt == FW'(FILL_LEN));
  assign resync_o = resync;

endmodule

`default_nettype wire

// File: tb/tb_dvbc_deinterleaver.sv
// tb_dvbc_deinterleaver: randomized bench for dvbc_deinterleaver against a
// stream-level reference model and an end-to-end interleaver loopback.
`default_nettype none

module tb_dvbc_deinterleaver;
  import dvbc_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] data_i;
  logic         valid_i;
  logic         sync_i;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic         sync_o;
  logic         locked_o;
  logic         filled_o;
  logic         resync_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: accepted bytes since the last alignment, as {sync,data}.
  int stream[$];
  bit m_locked = 1'b0;
  int pkt[$];
  bit loop_on = 1'b0;

  dvbc_deinterleaver dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .sync_i   (sync_i),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .sync_o   (sync_o),
    .locked_o (locked_o),
    .filled_o (filled_o),
    .resync_o (resync_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance, then check the byte just presented.
  task automatic step(input bit v, input bit s, input logic [7:0] d);
    bit acc;
    bit exp_resync;
    int k;
    int dly;
    int w;
    valid_i = v;
    sync_i  = s;
    data_i  = d;
    acc        = v && (m_locked || s);
    exp_resync = 1'b0;
    if (acc && s && (stream.size() % I != 0)) begin
      exp_resync = 1'b1;
      stream.delete();
    end
    if (acc && s) m_locked = 1'b1;
    if (acc) stream.push_back({s, d});
    @(posedge clk_i);
    #1;
    check_val("valid_o", valid_o, acc);
    check_val("locked_o", locked_o, m_locked);
    check_val("resync_o", resync_o, exp_resync);
    if (acc) begin
      k   = stream.size() - 1;
      dly = (I - 1 - k % I) * M * I;
      check_val("filled_o", filled_o, (k + 1 >= FILL_LEN));
      if (k >= dly) begin
        w = stream[k - dly];
        check_val("data_o", data_o, w[7:0]);
        check_val("sync_o", sync_o, w[8]);
      end
      if (loop_on && k >= FILL_LEN && (k - FILL_LEN) < pkt.size()) begin
        check_val("loopback", data_o, pkt[k - FILL_LEN]);
      end
    end else begin
      check_val("data_o idle", data_o, 0);
      check_val("sync_o idle", sync_o, 0);
    end
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, " valid_o"}, valid_o, 0);
    check_val({tag, " data_o"}, data_o, 0);
    check_val({tag, " sync_o"}, sync_o, 0);
    check_val({tag, " locked_o"}, locked_o, 0);
    check_val({tag, " filled_o"}, filled_o, 0);
    check_val({tag, " resync_o"}, resync_o, 0);
  endtask

  task automatic async_reset();
    #2 rst_i = 1'b1;
    #1 check_cleared("async_rst");
    #2 rst_i = 1'b0;
    stream.delete();
    m_locked = 1'b0;
  endtask

  task automatic lock_sequence();
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    step(1'b1, 1'b1, SYNC_BYTE);
  endtask

  initial begin
    int tx[];
    int n;
    int m;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    sync_i  = 1'b0;
    data_i  = '0;
    repeat (3) @(posedge clk_i);
    #1 check_cleared("reset");
    rst_i = 1'b0;

    // Packets through a golden transmit interleaver: pkt[n] -> tx[n + (n%I)*M*I].
    for (int p = 0; p < 20; p++) begin
      pkt.push_back(SYNC_BYTE);
      for (int b = 1; b < 204; b++) pkt.push_back($urandom_range(0, 255));
    end
    tx = new[pkt.size()];
    foreach (tx[i]) tx[i] = $urandom_range(0, 255);
    for (int i = 0; i < pkt.size(); i++) begin
      m = i + (i % I) * M * I;
      if (m < tx.size()) tx[m] = pkt[i];
    end

    // Lock from an unaligned stream, then continuous interleaved traffic.
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    loop_on = 1'b1;
    foreach (tx[i]) step(1'b1, (i % 204 == 0), 8'(tx[i]));
    loop_on = 1'b0;

    // Misaligned sync at branch 5, then gapped ramp traffic with syncs.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b1, SYNC_BYTE);
    n = 1;
    while (n < FILL_LEN + 300) begin
      if ($urandom_range(0, 1) == 1) begin
        step(1'b1, (n % 204 == 0), 8'(n));
        n++;
      end else begin
        step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
    end

    // Asynchronous reset mid-stream, then re-lock with gaps.
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b0, 8'(i));
    async_reset();
    lock_sequence();
    n = 1;
    while (n < 400) begin
      if ($urandom_range(0, 1) == 1) begin
        step(1'b1, 1'b0, 8'(n));
        n++;
      end else begin
        step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dvbc_deinterleaver.md
Name: dvbc_deinterleaver

Overview:
Convolutional (Forney) deinterleaver for the DVB-C receive path, per ETSI EN 300429 (I=12, M=17). It undoes the transmit interleaver by delaying branch j by (I-1-j)*M branch visits. Input is a byte stream from the QAM demapper/byte packer; output goes to the RS(204,188) decoder. It aligns its branch commutator to packet sync bytes and forwards a sync flag aligned with output packet starts.

Parameters:
I, 12, number of branches (interleaving depth)
M, 17, FIFO unit length in bytes (204/I)
W, 8, data width in bits

Ports:
clk_i  in  1  byte clock
rst_i  in  1  reset, asynchronous, active-high
data_i  in  W  interleaved byte
valid_i  in  1  data_i valid this cycle; no backpressure
sync_i  in  1  qualifies data_i as packet sync byte (first byte of 204-byte packet); only sampled with valid_i
data_o  out  W  deinterleaved byte
valid_o  out  1  data_o valid
sync_o  out  1  data_o is a packet sync byte
locked_o  out  1  commutator aligned to a received sync
filled_o  out  1  every branch holds post-alignment data; output is meaningful
resync_o  out  1  one-cycle pulse: sync_i arrived with branch counter != 0

Behaviour:
- Reset values: data_o=0, valid_o=0, sync_o=0, locked_o=0, filled_o=0, resync_o=0, branch counter=0, all branch pointers=0, fill counter=0. RAM contents are not reset.
- Storage: one RAM, DEPTH = M*I*(I-1)/2 = 1122 words of W+1 bits (data plus sync flag). Branch j (0..I-2) owns region base B_j = M*sum_{k<j}(I-1-k), length L_j = (I-1-j)*M. Branch I-1 has no storage (zero delay).
- Before lock: bytes with valid_i=1 and sync_i=0 are dropped. No RAM write, valid_o=0.
- Accepted byte (valid_i=1 and locked, or valid_i=1 and sync_i=1): branch b = current branch counter, or 0 if sync_i=1.
  - If b < I-1: read word at B_b+p_b, write {sync_i,data_i} at the same address (read-first), then p_b <= (p_b==L_b-1)?0:p_b+1.
  - If b = I-1: register {sync_i,data_i} directly.
  - Branch counter <= (b==I-1)?0:b+1.
- Latency: exactly one clk_i cycle from accepted input to valid_o. valid_o = registered accept. data_o and sync_o come from the RAM read word or bypass register. End-to-end, byte position n of the stream (counted from the sync) reappears at output position n + (I-1-(n mod I))*M*I.
- Sync handling:
  - sync_i with valid_i sets locked_o (sticky until reset) and forces branch 0.
  - If locked and the branch counter != 0 at that moment: resync_o pulses next cycle and the fill counter clears. Branch pointers are untouched.
  - sync_i with the counter already at 0: no event.
- Fill: counter increments per accepted byte and saturates at (I-1)*M*I = 2244. filled_o=1 when it reaches 2244. It is cleared by resync or reset.
- valid_i=0: no state change; valid_o=0 next cycle.
- Async reset mid-stream: all state returns to reset values immediately. Stale RAM data is masked until filled_o.

Decomposition:
- Package dvbc_pkg: constants I=12, M=17, W=8, SYNC_BYTE=8'h47, DEPTH=1122, FILL_LEN=2244, function branch_base(j), function branch_len(j).
- Sub-module dvbc_spram: single-port read-first synchronous RAM, parameterised width/depth, registered read. The same RAM serves a future interleaver.

Test Plan:
- Lock: send 30 bytes with sync_i=0, then sync 0x47 -> valid_o stays 0 for the 30 bytes; locked_o=1 the cycle after the sync; first valid_o one cycle after the sync.
- Bypass: after lock, feed stream value = n mod 256 -> byte n=11 (branch 11) appears at output position 11, one cycle after input.
- Branch delay: same stream -> input n=1 appears at output position 2041; n=0 (0x47, sync_i=1) appears at position 2244 with sync_o=1; filled_o rises at accepted byte 2244.
- Loopback: golden interleaver model feeding 20 packets of 204 bytes (sync 0x47, payload PRBS) -> after filled_o, the output equals the original packets. sync_o fires every 204 valid outputs on 0x47.
- Misaligned sync: assert sync_i at branch counter 5 -> resync_o pulses once, filled_o drops, the next byte is treated as branch 1, locked_o stays 1.
- Gaps and reset: random valid_i duty (~50%) gives the same output sequence as continuous input. rst_i asserted at byte 1000 clears all outputs asynchronously; re-lock then behaves as the Lock scenario.
